// File: rtl/sseg_scanner.sv
// sseg_scanner
//   Front end of the calculator's seven-segment display path. A 10-bit
//   binary result is converted to four BCD digits with a sequential
//   double-dabble (one shift per clock, ten clocks per conversion). The
//   four digits are then time-multiplexed onto a 4-digit common-anode
//   display. Each digit slot lasts REFRESH_DIV clocks.
//
//   Leading zeros can be blanked. A blanked digit is sent as code 4'hF,
//   which the downstream decoder renders with all segments off.
//
// Parameters
//   REFRESH_DIV   clocks per digit slot (>= 2)
//   BLANK_LEADING 1 = replace leading zeros with 4'hF, 0 = show all digits
//
// Ports
//   clk       in   rising-edge system clock
//   rst_n     in   asynchronous active-low reset
//   value_i   in   [9:0] binary value, captured when a load is accepted
//   load_i    in   conversion request, honoured only while busy_o = 0
//   busy_o    out  high while a conversion is in progress (10 cycles)
//   digit_o   out  [3:0] BCD code of the selected digit, or 4'hF = blank
//   anodes_o  out  [3:0] active-low digit enables, bit0 = ones

module sseg_scanner #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] value_i,
  input  logic       load_i,
  output logic       busy_o,
  output logic [3:0] digit_o,
  output logic [3:0] anodes_o
);

  localparam int unsigned            PW            = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]          LP_PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [3:0]             LP_NUM_BITS   = 4'd10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after
  // the following doubling, so pre-add 3 to push the carry into the next
  // decade.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  // Selects the digit for one slot and applies leading-zero blanking.
  // A position is blank only when it and every higher position are zero;
  // the ones position is always shown so that a value of 0 reads "0".
  function automatic logic [3:0] sel_digit(input logic [15:0] bcd,
                                           input logic [1:0]  idx);
    logic [3:0] th;
    logic [3:0] hu;
    logic [3:0] te;
    logic [3:0] on;
    logic [3:0] code;
    logic       blank;
    th    = bcd[15:12];
    hu    = bcd[11:8];
    te    = bcd[7:4];
    on    = bcd[3:0];
    code  = on;
    blank = 1'b0;
    case (idx)
      2'd0: begin
        code  = on;
        blank = 1'b0;
      end
      2'd1: begin
        code  = te;
        blank = (te == 4'd0) && (hu == 4'd0) && (th == 4'd0);
      end
      2'd2: begin
        code  = hu;
        blank = (hu == 4'd0) && (th == 4'd0);
      end
      default: begin
        code  = th;
        blank = (th == 4'd0);
      end
    endcase
    if (BLANK_LEADING && blank) begin
      code = 4'hF;
    end
    return code;
  endfunction

  // Conversion state
  state_t        r_state;
  state_t        w_state_nxt;
  logic [9:0]    r_bin;
  logic [9:0]    w_bin_nxt;
  logic [15:0]   r_bcd_work;
  logic [15:0]   w_bcd_work_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic [15:0]   r_bcd_disp;
  logic [15:0]   w_bcd_disp_nxt;

  logic [15:0]   w_bcd_adj;
  logic [25:0]   w_shifted;

  // Scan state
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          w_presc_wrap;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_nxt;
  logic [3:0]    r_digit;
  logic [3:0]    w_digit_nxt;
  logic [3:0]    r_anodes;
  logic [3:0]    w_anodes_nxt;

  // ---- conversion datapath: adjust then shift {bcd, bin} left by one
  assign w_bcd_adj = {add3(r_bcd_work[15:12]), add3(r_bcd_work[11:8]),
                      add3(r_bcd_work[7:4]),   add3(r_bcd_work[3:0])};
  assign w_shifted = {w_bcd_adj[14:0], r_bin, 1'b0};

  always_comb begin
    w_state_nxt    = r_state;
    w_bin_nxt      = r_bin;
    w_bcd_work_nxt = r_bcd_work;
    w_cnt_nxt      = r_cnt;
    w_bcd_disp_nxt = r_bcd_disp;
    case (r_state)
      ST_IDLE: begin
        if (load_i) begin
          w_bin_nxt      = value_i;
          w_bcd_work_nxt = 16'h0000;
          w_cnt_nxt      = LP_NUM_BITS;
          w_state_nxt    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_bcd_work_nxt = w_shifted[25:10];
        w_bin_nxt      = w_shifted[9:0];
        w_cnt_nxt      = r_cnt - 4'd1;
        // Last shift: the finished result goes straight to the display
        // registers so the shown value switches in a single edge.
        if (r_cnt == 4'd1) begin
          w_bcd_disp_nxt = w_shifted[25:10];
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bin      <= 10'd0;
      r_bcd_work <= 16'h0000;
      r_cnt      <= 4'd0;
      r_bcd_disp <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_bin      <= w_bin_nxt;
      r_bcd_work <= w_bcd_work_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bcd_disp <= w_bcd_disp_nxt;
    end
  end

  // ---- scan: free-running prescaler and digit index, never paused
  assign w_presc_wrap = (r_presc == LP_PRESC_LAST);
  assign w_presc_nxt  = w_presc_wrap ? '0 : (r_presc + 1'b1);
  assign w_idx_nxt    = w_presc_wrap ? (r_idx + 2'd1) : r_idx;

  // Output registers are loaded from the next index and next display
  // value, so digit_o and anodes_o always agree with each other and a
  // finished conversion appears on the same edge it is committed.
  always_comb begin
    w_anodes_nxt            = 4'b1111;
    w_anodes_nxt[w_idx_nxt] = 1'b0;
    w_digit_nxt             = sel_digit(w_bcd_disp_nxt, w_idx_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_idx    <= 2'd0;
      r_digit  <= 4'h0;
      r_anodes <= 4'b1110;
    end else begin
      r_presc  <= w_presc_nxt;
      r_idx    <= w_idx_nxt;
      r_digit  <= w_digit_nxt;
      r_anodes <= w_anodes_nxt;
    end
  end

  assign busy_o   = (r_state == ST_SHIFT);
  assign digit_o  = r_digit;
  assign anodes_o = r_anodes;

endmodule
